// File: rtl/hex_led_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_led_pkg : 7-segment glyph constants and page type                |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
package hex_led_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Active-low {g,f,e,d,c,b,a}; entry 0 is the rightmost element, "b"/"d" lowercase.
  localparam logic [15:0][6:0] SEG_GLYPHS = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

  typedef enum logic {
    PAGE_LO = 1'b0,
    PAGE_HI = 1'b1
  } page_e;

endpackage
`default_nettype wire

// File: rtl/hex_led_display_sink_hex7seg_enc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex7seg_enc : 4-bit nibble to active-low 7-segment glyph             |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
module hex7seg_enc
  import hex_led_pkg::*;
(
  input  logic [3:0] nibble_in,
  output logic [6:0] seg_out
);

  assign seg_out = SEG_GLYPHS[nibble_in];

endmodule
`default_nettype wire

// File: rtl/hex_led_display_sink.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hex_led_display_sink : debounced hex/LED word renderer with paging   |
// | Revision             : 1.0                                           |
// +----------------------------------------------------------------------+
module hex_led_display_sink
  import hex_led_pkg::*;
#(
  parameter int STABLE_CYCLES = 1024,
  parameter int PAGE_CYCLES   = 50000000,
  parameter int FLASH_CYCLES  = 5000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic [31:0] readdata_in,
  input  logic        page_mode_in,
  input  logic        page_sel_in,
  output logic [6:0]  hex0_out,
  output logic [6:0]  hex1_out,
  output logic [6:0]  hex2_out,
  output logic [6:0]  hex3_out,
  output logic [6:0]  hex4_out,
  output logic [6:0]  hex5_out,
  output logic [9:0]  ledr_out,
  output logic        update_pulse_out
);

  localparam int SW = $clog2(STABLE_CYCLES);
  localparam int PW = (PAGE_CYCLES > 1) ? $clog2(PAGE_CYCLES) : 1;
  localparam int FW = $clog2(FLASH_CYCLES + 1);
  localparam logic [SW-1:0] STAB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [PW-1:0] PAGE_LAST  = PW'(PAGE_CYCLES - 1);
  localparam logic [FW-1:0] FLASH_LOAD = FW'(FLASH_CYCLES);

  logic [31:0]      sample_q, sample_d;
  logic [31:0]      shown_q, shown_d;
  logic [SW-1:0]    stab_cnt_q, stab_cnt_d;
  logic             accept_q, accept_d;
  logic [FW-1:0]    flash_cnt_q, flash_cnt_d;
  logic [PW-1:0]    page_tmr_q, page_tmr_d;
  page_e            page_q, page_d;
  logic             manual_q, manual_d;
  logic             pulse_q, pulse_d;
  logic [5:0][6:0]  hex_q, hex_d;
  logic [9:0]       ledr_q, ledr_d;
  logic [5:0][6:0]  seg_w;
  logic             match;

  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    logic [3:0] nib;
    if (gi < 2) begin : g_pageable
      assign nib = (page_q == PAGE_HI) ? shown_q[24+4*gi +: 4] : shown_q[4*gi +: 4];
    end else begin : g_fixed
      assign nib = shown_q[4*gi +: 4];
    end
    hex7seg_enc u_enc (
      .nibble_in (nib),
      .seg_out   (seg_w[gi])
    );
  end

  always_comb begin
    sample_d = readdata_in;
    match    = (readdata_in == sample_q);

    if (!match)                    stab_cnt_d = '0;
    else if (stab_cnt_q == STAB_LAST) stab_cnt_d = stab_cnt_q;
    else                           stab_cnt_d = stab_cnt_q + SW'(1);

    // Acceptance is decided one cycle ahead and committed on the next edge;
    // the !accept_q term stops the still-true condition from re-arming.
    accept_d = match && (stab_cnt_q == STAB_LAST) && (sample_q != shown_q) && !accept_q;
    shown_d  = accept_q ? sample_q : shown_q;
    pulse_d  = accept_q;

    if (accept_q)               flash_cnt_d = FLASH_LOAD;
    else if (flash_cnt_q != '0) flash_cnt_d = flash_cnt_q - FW'(1);
    else                        flash_cnt_d = flash_cnt_q;

    manual_d   = page_mode_in;
    page_d     = page_q;
    page_tmr_d = page_tmr_q;
    if (page_mode_in) begin
      page_d     = page_e'(page_sel_in);
      page_tmr_d = '0;
    end else if (accept_q || manual_q || (shown_q[31:24] == 8'h00)) begin
      page_d     = PAGE_LO;
      page_tmr_d = '0;
    end else if (page_tmr_q == PAGE_LAST) begin
      page_d     = (page_q == PAGE_LO) ? PAGE_HI : PAGE_LO;
      page_tmr_d = '0;
    end else begin
      page_tmr_d = page_tmr_q + PW'(1);
    end

    hex_d = seg_w;
    if (page_q == PAGE_HI) begin
      hex_d[2] = SEG_BLANK;
      hex_d[3] = SEG_BLANK;
      hex_d[4] = SEG_BLANK;
      hex_d[5] = SEG_P;
    end
    ledr_d = {(flash_cnt_q != '0), (page_q == PAGE_HI), shown_q[31:24]};
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sample_q    <= '0;
      shown_q     <= '0;
      stab_cnt_q  <= '0;
      accept_q    <= 1'b0;
      flash_cnt_q <= '0;
      page_tmr_q  <= '0;
      page_q      <= PAGE_LO;
      manual_q    <= 1'b0;
      pulse_q     <= 1'b0;
      hex_q       <= {6{SEG_ZERO}};
      ledr_q      <= '0;
    end else begin
      sample_q    <= sample_d;
      shown_q     <= shown_d;
      stab_cnt_q  <= stab_cnt_d;
      accept_q    <= accept_d;
      flash_cnt_q <= flash_cnt_d;
      page_tmr_q  <= page_tmr_d;
      page_q      <= page_d;
      manual_q    <= manual_d;
      pulse_q     <= pulse_d;
      hex_q       <= hex_d;
      ledr_q      <= ledr_d;
    end
  end

  assign hex0_out         = hex_q[0];
  assign hex1_out         = hex_q[1];
  assign hex2_out         = hex_q[2];
  assign hex3_out         = hex_q[3];
  assign hex4_out         = hex_q[4];
  assign hex5_out         = hex_q[5];
  assign ledr_out         = ledr_q;
  assign update_pulse_out = pulse_q;

endmodule
`default_nettype wire
